imem_loader: RTL
================

Name: imem_loader

Overview:
- Write-side companion to the instruction memory. Receives a byte stream (UART or debug bridge) holding a length header and a program image.
- Assembles little-endian 32-bit instruction words and issues single-cycle writes at consecutive word addresses.
- Holds the CPU in reset until the image is fully loaded.
- Sits between the boot/debug byte source and the instruction memory write port.

Parameters:
- ADDR_W, 64, width of write address; matches PC width.
- BASE_ADDR, 0, byte address of the first instruction word.
- MAX_WORDS, 256, largest accepted program length in words.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load
- byte_in  input  8  stream data byte
- byte_valid  input  1  byte_in valid
- byte_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  instruction memory write strobe
- wr_addr  output  ADDR_W  byte address of the word being written
- wr_data  output  32  instruction word
- cpu_hold  output  1  keeps the CPU in reset while high
- done  output  1  level; image loaded successfully
- error  output  1  level; load aborted

Behaviour:
- Reset (async, active-high): state IDLE, all outputs 0 except cpu_hold=1; word counter, length and shift register cleared. Reset asserted mid-load aborts immediately; no further wr_en.
- Byte transfer: a byte is accepted on a rising edge where byte_valid && byte_ready. byte_ready is high only in LEN0, LEN1 and DATA (and CSUM when enabled).
- All outputs are registered.
- States:
  - IDLE: start -> LEN0.
  - LEN0: accepted byte -> len[7:0]; go to LEN1.
  - LEN1: accepted byte -> len[15:8]; next state chosen from the full 16-bit len:
    - len==0 -> DONE (or CSUM when enabled);
    - len>MAX_WORDS -> ERR;
    - otherwise -> DATA.
  - DATA: byte k of the current word goes to bits [8k+7:8k], k=0..3. After the 4th byte -> WRITE.
  - WRITE: exactly one cycle with wr_en=1, wr_addr=BASE_ADDR+4*idx, wr_data=assembled word.
    - wr_addr is truncated to ADDR_W.
    - Then idx increments. If idx==len -> DONE (or CSUM); else -> DATA.
  - DONE: done=1, cpu_hold=0. start -> LEN0 (reload): done clears, cpu_hold=1, idx=0.
  - ERR: error=1, cpu_hold=1. start -> LEN0, error clears.
- cpu_hold is 1 in every state except DONE.
- Latency: wr_en rises the cycle after the edge that accepted the 4th byte of a word.
- Maximum throughput: one word per 5 cycles.
- Gaps in byte_valid stall the state with no side effects.
- wr_addr and wr_data hold their last values when wr_en=0.
- start is ignored in LEN0, LEN1, DATA, WRITE and CSUM; there is no restart mid-load except via reset.
- idx is 16 bits wide. Header bytes are not written to memory.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of all payload bytes, excluding the header.
  - After the last WRITE (or after LEN1 when len==0), state CSUM accepts one byte.
  - Byte equals the running XOR -> DONE; mismatch -> ERR.
  - XOR is cleared on every entry to LEN0.
- Undefined: no CSUM state; transitions go directly to DONE.

Test Plan:
- Reset mid-load: assert reset during the 2nd data byte of word 0 -> outputs immediately cpu_hold=1, done=0, error=0, wr_en=0; no write occurs.
- Two-word load: start; bytes 02 00, 13 01 10 00, 33 01 10 00 (no gaps) -> exactly two writes:
  - wr_en pulses (0x0, 0x00100113) and (0x4, 0x00100133), each 1 cycle after its 4th byte;
  - done=1 and cpu_hold=0 after the second write.
- Zero length: start; bytes 00 00 -> no wr_en; done=1 one cycle after the 2nd header byte.
- Over-length: start; bytes 01 01 (257 > 256) -> error=1, cpu_hold=1, byte_ready=0, no writes. A subsequent start plus a valid image loads normally.
- Stalled stream: one-word load with byte_valid low for 3 cycles between every byte -> a single write (0x0, 0x00100133); byte_ready stays high during gaps.
- Checksum (macro defined): image 01 00, 33 01 10 00 followed by byte 0x22 -> done=1. Followed by 0x23 instead -> error=1, with the single write still having occurred.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: write-side companion to the instruction memory.
// Takes a byte stream carrying a 16-bit little-endian word count followed by
// the program image, packs little-endian 32-bit words and writes each to
// consecutive word addresses. The CPU is held in reset until the image lands.
// Optional: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte after the payload before the load is reported as done.
//
// state | meaning
// IDLE  | waiting for start after reset
// LEN0  | expecting length low byte
// LEN1  | expecting length high byte, range check
// DATA  | collecting the 4 bytes of the current word
// WRITE | one-cycle write strobe to instruction memory
// DONE  | image loaded, CPU released
// ERR   | load aborted (length out of range or checksum mismatch)
// CSUM  | expecting checksum byte (checksum build only)
module imem_loader #(
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR, S_CSUM
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CSUM;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t            state, state_nxt;
    logic [15:0]       len, idx, idx_inc, len_full;
    logic [1:0]        cnt;
    logic [23:0]       shreg;
    logic [31:0]       word_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              accept;
    logic              byte_ready_nxt, wr_en_nxt, done_nxt, error_nxt, cpu_hold_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign accept   = byte_valid && byte_ready;
    assign len_full = {byte_in, len[7:0]};
    assign idx_inc  = idx + 16'd1;
    // shreg holds the first three bytes of the word; the fourth arrives live
    assign word_nxt = {byte_in, shreg};
    assign addr_nxt = BASE_ADDR + ADDR_W'({idx, 2'b00});

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LEN0;
            S_LEN0:  if (accept) state_nxt = S_LEN1;
            S_LEN1: begin
                if (accept) begin
                    if (len_full == 16'd0)                 state_nxt = S_FIN;
                    else if (32'(len_full) > MAX_WORDS)    state_nxt = S_ERR;
                    else                                   state_nxt = S_DATA;
                end
            end
            S_DATA:  if (accept && cnt == 2'd3) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (idx_inc == len) ? S_FIN : S_DATA;
            S_DONE:  if (start) state_nxt = S_LEN0;
            S_ERR:   if (start) state_nxt = S_LEN0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:  if (accept) state_nxt = (byte_in == csum) ? S_DONE : S_ERR;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // output decode of the upcoming state, registered below
    always_comb begin
        byte_ready_nxt = (state_nxt == S_LEN0) || (state_nxt == S_LEN1) ||
                         (state_nxt == S_DATA) || (state_nxt == S_CSUM);
        wr_en_nxt      = (state_nxt == S_WRITE);
        done_nxt       = (state_nxt == S_DONE);
        error_nxt      = (state_nxt == S_ERR);
        cpu_hold_nxt   = (state_nxt != S_DONE);
    end

    // registered outputs; address/data only move when a write is issued
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            byte_ready <= byte_ready_nxt;
            wr_en      <= wr_en_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            cpu_hold   <= cpu_hold_nxt;
            if (wr_en_nxt) begin
                wr_addr <= addr_nxt;
                wr_data <= word_nxt;
            end
        end
    end

    // length capture, word assembly and word index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len   <= '0;
            idx   <= '0;
            cnt   <= '0;
            shreg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            if (state_nxt == S_LEN0 && state != S_LEN0) begin
                idx  <= '0;
                cnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum <= '0;
`endif
            end
            if (accept) begin
                case (state)
                    S_LEN0: len[7:0]  <= byte_in;
                    S_LEN1: len[15:8] <= byte_in;
                    S_DATA: begin
                        shreg <= {byte_in, shreg[23:8]};
                        cnt   <= cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum  <= csum ^ byte_in;
`endif
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) idx <= idx_inc;
        end
    end

endmodule
